// File: rtl/riscv_biu_arb.sv
// Arbitrates the single core memory bus between instruction fetch and data access.
// Round-robin on simultaneous requests, with a per-transaction acknowledge timeout.
module riscv_biu_arb #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_adr,
    output logic              if_ack,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [XLEN/8-1:0] dm_be,
    input  logic [XLEN-1:0]   dm_adr,
    input  logic [XLEN-1:0]   dm_wdata,
    output logic              dm_ack,
    output logic              dm_err,
    output logic [XLEN-1:0]   rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN/8-1:0] bus_be,
    output logic [XLEN-1:0]   bus_adr,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [XLEN-1:0]   bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic             owner_dm;
    logic             last_dm;
    logic [CNT_W-1:0] cnt;
    logic             grant;
    logic             grant_dm;
    logic             done;
    logic             tmo;
    logic             ack_any;
    logic             err_any;

    assign grant    = (state == IDLE) && (if_req || dm_req);
    // On a tie, DM wins only when IF had the previous grant.
    assign grant_dm = dm_req && (!if_req || !last_dm);
    assign done     = bus_ack || bus_err;
    assign tmo      = (cnt == TO_LAST) && !done;

    assign bus_req  = (state == BUSY);
    assign rdata    = bus_rdata;

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = BUSY;
            BUSY:    if (done || tmo) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Completion is routed combinationally; a bus error masks a simultaneous ack.
    always_comb begin
        ack_any = 1'b0;
        err_any = 1'b0;
        if (state == BUSY && rstn) begin
            ack_any = bus_ack && !bus_err;
            err_any = bus_err || tmo;
        end
        if_ack = ack_any && !owner_dm;
        if_err = err_any && !owner_dm;
        dm_ack = ack_any && owner_dm;
        dm_err = err_any && owner_dm;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            owner_dm  <= 1'b0;
            last_dm   <= 1'b0;
            cnt       <= '0;
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_adr   <= '0;
            bus_wdata <= '0;
        end else if (grant) begin
            owner_dm  <= grant_dm;
            last_dm   <= grant_dm;
            cnt       <= '0;
            bus_we    <= grant_dm ? dm_we : 1'b0;
            bus_be    <= grant_dm ? dm_be : '1;
            bus_adr   <= grant_dm ? dm_adr : if_adr;
            bus_wdata <= grant_dm ? dm_wdata : '0;
        end else if (state == BUSY && !done) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule
